// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file.
// Contents:
//   WIDTH_DEF / DEPTH_DEF / ADDR_W_DEF - default geometry of the lab register file
//   reg_addr_t                         - register address type at the default width
//   addr_valid()                       - true when an address names a real, writable register
package lab_pkg;

  localparam int WIDTH_DEF  = 9;
  localparam int DEPTH_DEF  = 4;
  localparam int ADDR_W_DEF = 2;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // An address is usable when it is below the populated depth and is not the
  // hardwired-zero register (when that option is enabled).
  function automatic logic addr_valid(input int addr, input int depth, input logic zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_file_mp_rd_port.sv
// One combinational read port of reg_file_mp.
// Ports:
//   rd_addr              - register to read
//   wr0_ok/addr/data     - write port 0, already qualified (enable && valid address)
//   wr1_ok/addr/data     - write port 1, already qualified, wins over port 0
//   mem_flat             - all storage words, register i at [i*WIDTH +: WIDTH]
//   pending              - current pending mask
//   rd_data / rd_ready   - read value and its validity
module reg_file_rd_port
  import lab_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic                   wr0_ok,
  input  logic [ADDR_W-1:0]      wr0_addr,
  input  logic [WIDTH-1:0]       wr0_data,
  input  logic                   wr1_ok,
  input  logic [ADDR_W-1:0]      wr1_addr,
  input  logic [WIDTH-1:0]       wr1_data,
  input  logic [DEPTH*WIDTH-1:0] mem_flat,
  input  logic [DEPTH-1:0]       pending,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_ready
);

  logic             rd_ok;
  logic [WIDTH-1:0] stored;
  logic             stored_pend;
  logic             hit0;
  logic             hit1;

  assign rd_ok = addr_valid(int'(rd_addr), DEPTH, ZERO_REG != 0);

  // Explicit decode loop keeps the index in range when DEPTH < 2**ADDR_W.
  always_comb begin
    stored      = '0;
    stored_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        stored      = mem_flat[i*WIDTH +: WIDTH];
        stored_pend = pending[i];
      end
    end
  end

  assign hit1 = (BYPASS != 0) && wr1_ok && (wr1_addr == rd_addr);
  assign hit0 = (BYPASS != 0) && wr0_ok && (wr0_addr == rd_addr);

  // Forwarded data is always ready: the write in flight is the result the
  // reader was waiting for. Port 1 is checked first to match storage priority.
  always_comb begin
    rd_data  = stored;
    rd_ready = !stored_pend;
    if (!rd_ok) begin
      rd_data  = '0;
      rd_ready = 1'b1;
    end else if (hit1) begin
      rd_data  = wr1_data;
      rd_ready = 1'b1;
    end else if (hit0) begin
      rd_data  = wr0_data;
      rd_ready = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with pending scoreboard.
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   wr0_* / wr1_*             - two write ports, wr1 wins on an address collision
//   rsv_en / rsv_addr         - mark a register pending (producer issued)
//   rd0_* / rd1_*             - combinational read ports with data and ready
//   pending                   - registered pending mask, bit i = register i reserved
module reg_file_mp
  import lab_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [WIDTH-1:0]  wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [WIDTH-1:0]  wr1_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [WIDTH-1:0]  rd0_data,
  output logic              rd0_ready,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [WIDTH-1:0]  rd1_data,
  output logic              rd1_ready,
  output logic [DEPTH-1:0]  pending
);

  logic                   wr0_ok;
  logic                   wr1_ok;
  logic                   rsv_ok;
  logic [DEPTH*WIDTH-1:0] mem_flat;

  assign wr0_ok = wr0_en && addr_valid(int'(wr0_addr), DEPTH, ZERO_REG != 0);
  assign wr1_ok = wr1_en && addr_valid(int'(wr1_addr), DEPTH, ZERO_REG != 0);
  assign rsv_ok = rsv_en && addr_valid(int'(rsv_addr), DEPTH, ZERO_REG != 0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [WIDTH-1:0] data_d;
      logic [WIDTH-1:0] data_q;
      logic             pend_d;
      logic             pend_q;
      logic             hit0;
      logic             hit1;
      logic             hit_rsv;

      assign hit0    = wr0_ok && (wr0_addr == ADDR_W'(gi));
      assign hit1    = wr1_ok && (wr1_addr == ADDR_W'(gi));
      assign hit_rsv = rsv_ok && (rsv_addr == ADDR_W'(gi));

      always_comb begin
        data_d = data_q;
        if (hit1) begin
          data_d = wr1_data;
        end else if (hit0) begin
          data_d = wr0_data;
        end
        // A write completes the old producer; a same-cycle reserve names a
        // new producer, so the set is applied last and wins.
        pend_d = pend_q;
        if (hit0 || hit1) begin
          pend_d = 1'b0;
        end
        if (hit_rsv) begin
          pend_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= '0;
          pend_q <= 1'b0;
        end else begin
          data_q <= data_d;
          pend_q <= pend_d;
        end
      end

      assign mem_flat[gi*WIDTH +: WIDTH] = data_q;
      assign pending[gi]                 = pend_q;
    end
  endgenerate

  reg_file_rd_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd0 (
    .rd_addr  (rd0_addr),
    .wr0_ok   (wr0_ok),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_ok   (wr1_ok),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .mem_flat (mem_flat),
    .pending  (pending),
    .rd_data  (rd0_data),
    .rd_ready (rd0_ready)
  );

  reg_file_rd_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd1 (
    .rd_addr  (rd1_addr),
    .wr0_ok   (wr0_ok),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_ok   (wr1_ok),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .mem_flat (mem_flat),
    .pending  (pending),
    .rd_data  (rd1_data),
    .rd_ready (rd1_ready)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp. Three instances share one stimulus stream:
//   k=0: defaults (ZERO_REG=0, BYPASS=1, ADDR_W=2)
//   k=1: BYPASS=0
//   k=2: ZERO_REG=1, BYPASS=1, ADDR_W=3 (addresses 4..7 out of range)
// The 2-bit instances see the low two bits of each address.
module tb_reg_file_mp;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr0_en, wr1_en, rsv_en;
  logic [2:0] wr0_addr, wr1_addr, rsv_addr, rd0_addr, rd1_addr;
  logic [8:0] wr0_data, wr1_data;

  logic [8:0] rd0_d [3];
  logic [8:0] rd1_d [3];
  logic       rd0_r [3];
  logic       rd1_r [3];
  logic [3:0] pend_o [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain arrays per configuration.
  logic [8:0] m_mem  [3][8];
  logic       m_pend [3][8];
  bit         cfg_zero [3] = '{1'b0, 1'b0, 1'b1};
  bit         cfg_byp  [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  reg_file_mp #(.WIDTH(9), .DEPTH(4), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr[1:0]), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr[1:0]), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr[1:0]),
    .rd0_addr(rd0_addr[1:0]), .rd0_data(rd0_d[0]), .rd0_ready(rd0_r[0]),
    .rd1_addr(rd1_addr[1:0]), .rd1_data(rd1_d[0]), .rd1_ready(rd1_r[0]),
    .pending(pend_o[0]));

  reg_file_mp #(.WIDTH(9), .DEPTH(4), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr[1:0]), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr[1:0]), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr[1:0]),
    .rd0_addr(rd0_addr[1:0]), .rd0_data(rd0_d[1]), .rd0_ready(rd0_r[1]),
    .rd1_addr(rd1_addr[1:0]), .rd1_data(rd1_d[1]), .rd1_ready(rd1_r[1]),
    .pending(pend_o[1]));

  reg_file_mp #(.WIDTH(9), .DEPTH(4), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd0_addr(rd0_addr), .rd0_data(rd0_d[2]), .rd0_ready(rd0_r[2]),
    .rd1_addr(rd1_addr), .rd1_data(rd1_d[2]), .rd1_ready(rd1_r[2]),
    .pending(pend_o[2]));

  // ---------------- reference model ----------------
  function automatic int eff(int k, logic [2:0] a);
    return (k == 2) ? int'(a) : int'(a[1:0]);
  endfunction

  function automatic bit mvalid(int k, logic [2:0] a);
    int e = eff(k, a);
    return (e < 4) && !(cfg_zero[k] && e == 0);
  endfunction

  // Expected {ready, data} for a read of address a in configuration k.
  function automatic logic [9:0] exp_rd(int k, logic [2:0] a);
    int e = eff(k, a);
    if (!mvalid(k, a)) return {1'b1, 9'h000};
    if (cfg_byp[k] && wr1_en && mvalid(k, wr1_addr) && eff(k, wr1_addr) == e)
      return {1'b1, wr1_data};
    if (cfg_byp[k] && wr0_en && mvalid(k, wr0_addr) && eff(k, wr0_addr) == e)
      return {1'b1, wr0_data};
    return {~m_pend[k][e], m_mem[k][e]};
  endfunction

  function automatic logic [3:0] exp_pend(int k);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = m_pend[k][i];
    return p;
  endfunction

  // One clock edge: DUT and model both consume the inputs currently driven.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          m_mem[k][i]  = 9'h000;
          m_pend[k][i] = 1'b0;
        end
      end else begin
        if (wr0_en && mvalid(k, wr0_addr)) begin
          m_mem[k][eff(k, wr0_addr)]  = wr0_data;
          m_pend[k][eff(k, wr0_addr)] = 1'b0;
        end
        if (wr1_en && mvalid(k, wr1_addr)) begin
          m_mem[k][eff(k, wr1_addr)]  = wr1_data;
          m_pend[k][eff(k, wr1_addr)] = 1'b0;
        end
        if (rsv_en && mvalid(k, rsv_addr)) m_pend[k][eff(k, rsv_addr)] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
    wr0_addr = 3'd0; wr1_addr = 3'd0; rsv_addr = 3'd0;
    wr0_data = 9'h000; wr1_data = 9'h000;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle(); rst = 1'b1; rd0_addr = 3'd2; rd1_addr = 3'd1;
    tick(); tick();
    rst = 1'b0;
    wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 9'h1AA;
    tick();
    set_idle(); rst = 1'b1;
    tick();
    set_idle(); #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rd0_d[k] !== 9'h000 || rd0_r[k] !== 1'b1 || pend_o[k] !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset k=%0d: data=%h ready=%b pending=%b, need 000 1 0000",
                 k, rd0_d[k], rd0_r[k], pend_o[k]);
      end
    end
  endtask

  task automatic test_write_collision();
    set_idle();
    wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 9'h011;
    wr1_en = 1'b1; wr1_addr = 3'd1; wr1_data = 9'h122;
    tick();
    set_idle(); rd0_addr = 3'd1; #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rd0_d[k] !== 9'h122) begin
        n_fail++;
        $display("FAIL collision k=%0d: rd0=%h, need 122", k, rd0_d[k]);
      end
    end
    wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 9'h0AB;
    wr1_en = 1'b1; wr1_addr = 3'd3; wr1_data = 9'h0CD;
    tick();
    set_idle(); rd0_addr = 3'd0; rd1_addr = 3'd3; #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rd1_d[k] !== 9'h0CD || rd0_d[k] !== ((k == 2) ? 9'h000 : 9'h0AB)) begin
        n_fail++;
        $display("FAIL parallel_write k=%0d: rd0=%h rd1=%h, need %h 0CD",
                 k, rd0_d[k], rd1_d[k], (k == 2) ? 9'h000 : 9'h0AB);
      end
    end
  endtask

  task automatic test_bypass();
    set_idle(); wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 9'h033;
    tick();
    set_idle(); wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 9'h055; rd1_addr = 3'd3; #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rd1_d[k] !== ((k == 1) ? 9'h033 : 9'h055)) begin
        n_fail++;
        $display("FAIL bypass_same_cycle k=%0d: rd1=%h, need %h",
                 k, rd1_d[k], (k == 1) ? 9'h033 : 9'h055);
      end
    end
    tick();
    set_idle(); #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rd1_d[k] !== 9'h055) begin
        n_fail++;
        $display("FAIL bypass_next_cycle k=%0d: rd1=%h, need 055", k, rd1_d[k]);
      end
    end
  endtask

  task automatic test_scoreboard();
    set_idle(); rsv_en = 1'b1; rsv_addr = 3'd2;
    tick();
    set_idle(); rd0_addr = 3'd2; #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (pend_o[k] !== 4'b0100 || rd0_r[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reserve k=%0d: pending=%b ready=%b, need 0100 0", k, pend_o[k], rd0_r[k]);
      end
    end
    wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 9'h0F0; #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rd0_r[k] !== ((k == 1) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL ready_on_write k=%0d: ready=%b, need %b", k, rd0_r[k], k != 1);
      end
    end
    tick();
    set_idle(); #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (pend_o[k] !== 4'b0000 || rd0_d[k] !== 9'h0F0) begin
        n_fail++;
        $display("FAIL write_clears k=%0d: pending=%b rd0=%h, need 0000 0F0", k, pend_o[k], rd0_d[k]);
      end
    end
    rsv_en = 1'b1; rsv_addr = 3'd2; wr1_en = 1'b1; wr1_addr = 3'd2; wr1_data = 9'h012;
    tick();
    set_idle(); #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (pend_o[k] !== 4'b0100) begin
        n_fail++;
        $display("FAIL reserve_and_write k=%0d: pending=%b, need 0100", k, pend_o[k]);
      end
    end
  endtask

  task automatic test_zero_reg();
    set_idle(); wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 9'h1FF;
    tick();
    set_idle(); rd0_addr = 3'd0; #1;
    n_checks++;
    if (rd0_d[2] !== 9'h000 || rd0_r[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_reg_read: data=%h ready=%b, need 000 1", rd0_d[2], rd0_r[2]);
    end
    n_checks++;
    if (rd0_d[0] !== 9'h1FF) begin
      n_fail++;
      $display("FAIL nonzero_cfg_r0: data=%h, need 1FF", rd0_d[0]);
    end
    rsv_en = 1'b1; rsv_addr = 3'd0;
    tick();
    set_idle(); rd0_addr = 3'd5; #1;
    n_checks++;
    if (pend_o[2][0] !== 1'b0 || pend_o[0][0] !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_reg_reserve: pend_c[0]=%b pend_a[0]=%b, need 0 1", pend_o[2][0], pend_o[0][0]);
    end
    n_checks++;
    if (rd0_d[2] !== 9'h000 || rd0_r[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL out_of_range_read: data=%h ready=%b, need 000 1", rd0_d[2], rd0_r[2]);
    end
    wr1_en = 1'b1; wr1_addr = 3'd5; wr1_data = 9'h1EE; rd1_addr = 3'd1;
    tick();
    set_idle(); #1;
    n_checks++;
    if (rd1_d[2] !== 9'h122) begin
      n_fail++;
      $display("FAIL out_of_range_write: r1=%h, need 122", rd1_d[2]);
    end
  endtask

  task automatic test_reset_mid();
    set_idle(); rsv_en = 1'b1; rsv_addr = 3'd1;
    tick();
    rsv_addr = 3'd3;
    tick();
    set_idle(); rst = 1'b1; wr1_en = 1'b1; wr1_addr = 3'd1; wr1_data = 9'h077;
    tick();
    set_idle(); rd0_addr = 3'd1; #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rd0_d[k] !== 9'h000 || pend_o[k] !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d: r1=%h pending=%b, need 000 0000", k, rd0_d[k], pend_o[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] e0, e1;
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      wr0_en   = $urandom_range(0, 1) == 1;
      wr1_en   = $urandom_range(0, 2) == 0;
      rsv_en   = $urandom_range(0, 1) == 1;
      wr0_addr = 3'($urandom_range(0, 7));
      wr1_addr = 3'($urandom_range(0, 7));
      rsv_addr = 3'($urandom_range(0, 7));
      rd0_addr = 3'($urandom_range(0, 7));
      rd1_addr = 3'($urandom_range(0, 7));
      wr0_data = 9'($urandom);
      wr1_data = 9'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (pend_o[k] !== exp_pend(k)) begin
          n_fail++;
          $display("FAIL rand_pending n=%0d k=%0d: got %b, need %b", n, k, pend_o[k], exp_pend(k));
        end
        if (!rst) begin
          e0 = exp_rd(k, rd0_addr);
          e1 = exp_rd(k, rd1_addr);
          n_checks++;
          if ({rd0_r[k], rd0_d[k]} !== e0 || {rd1_r[k], rd1_d[k]} !== e1) begin
            n_fail++;
            $display("FAIL rand_read n=%0d k=%0d: rd0=%b/%h rd1=%b/%h, need %b/%h %b/%h",
                     n, k, rd0_r[k], rd0_d[k], rd1_r[k], rd1_d[k], e0[9], e0[8:0], e1[9], e1[8:0]);
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    set_idle(); rd0_addr = 3'd0; rd1_addr = 3'd0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i]  = 9'h000;
        m_pend[k][i] = 1'b0;
      end
    @(negedge clk);
    test_reset();
    test_write_collision();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the lab datapath. It is the next generation of the 4x9 single-write register file.
- Two write ports with fixed priority.
- Two combinational read ports with optional write-to-read bypass.
- Optional hardwired-zero register 0.
- Per-register pending scoreboard: the issue stage reserves a destination, and the writeback stage clears the reservation when it writes.

Parameters:
WIDTH, 9, data width in bits
DEPTH, 4, number of registers (2..2**ADDR_W)
ADDR_W, 2, address width
ZERO_REG, 0, 1 = register 0 reads 0; writes and reserves to it are ignored
BYPASS, 1, 1 = read ports forward same-cycle write data

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
wr0_en  in  1  write port 0 enable
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  WIDTH  write port 0 data
wr1_en  in  1  write port 1 enable (higher priority)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  WIDTH  write port 1 data
rsv_en  in  1  reserve request: mark register pending
rsv_addr  in  ADDR_W  register to reserve
rd0_addr  in  ADDR_W  read port 0 address
rd0_data  out  WIDTH  read port 0 data (combinational)
rd0_ready  out  1  read port 0 value is valid (not pending or bypassed)
rd1_addr  in  ADDR_W  read port 1 address
rd1_data  out  WIDTH  read port 1 data (combinational)
rd1_ready  out  1  read port 1 value is valid
pending  out  DEPTH  registered pending mask, bit i = register i reserved

Behaviour:
- Reset, when rst is sampled high at posedge:
  - all storage and the pending mask clear to 0;
  - writes and reserves in that cycle are ignored;
  - reset mid-operation discards outstanding reservations;
  - after the edge, rd*_data = 0, rd*_ready = 1, pending = 0.
- Writes:
  - a port with wrN_en=1 and a valid address updates storage[addr] at posedge;
  - both ports on the same address: wr1_data is stored;
  - both ports on different addresses: both are stored;
  - address >= DEPTH is ignored;
  - ZERO_REG=1 with address 0 is ignored.
- Reads:
  - rdN_data = storage[rdN_addr], purely combinational, zero latency;
  - address >= DEPTH returns 0 with ready=1;
  - ZERO_REG=1 with address 0 returns 0 with ready=1.
- Bypass (BYPASS=1):
  - if wr1 is enabled and writing a valid address equal to rdN_addr, rdN_data = wr1_data;
  - else if wr0 matches, rdN_data = wr0_data;
  - else storage;
  - this gives write-first semantics with wr1 priority, mirroring the storage priority.
- BYPASS=0: storage only; read-during-write returns the old value.
- Pending scoreboard:
  - rsv_en with a valid address sets pending[rsv_addr] at posedge;
  - any enabled valid write clears pending[addr];
  - reserve and write to the same address in the same cycle: pending ends at 1, because the new producer wins over the completing one;
  - reserving an already-pending register leaves it at 1 with no error;
  - writing a non-pending register is allowed and leaves it at 0.
- Ready:
  - rdN_ready = !pending[rdN_addr], OR (BYPASS=1 and a same-cycle write hits rdN_addr);
  - ready uses current-cycle pending only; a same-cycle reserve does not lower it.
- No backpressure on any port; every request completes in the cycle it is presented.

Decomposition:
- Shared package lab_pkg:
  - default WIDTH/DEPTH/ADDR_W constants;
  - the register-address typedef;
  - a function addr_valid(addr) (range check plus zero-register check).
- One sub-module, reg_file_rd_port, instantiated twice. It performs address decode, bypass mux and ready generation for one read port, from storage, pending and both write ports.
- Storage, write priority and the scoreboard stay in the top module.

Test Plan:
1. Reset: write 9'h1AA to r2, then assert rst one cycle -> rd0(r2)=0, rd0_ready=1, pending=4'b0000.
2. Write collision: wr0 r1=9'h011 and wr1 r1=9'h122 in the same cycle -> next cycle rd0(r1)=9'h122. Also with r0/r3 in parallel: both stored.
3. Bypass: BYPASS=1, wr0 r3=9'h055 while rd1_addr=3 -> rd1_data=9'h055 in the same cycle. BYPASS=0 -> old value in the same cycle, 9'h055 next cycle.
4. Scoreboard:
   - rsv r2 -> pending=4'b0100, rd0_ready(r2)=0;
   - write r2=9'h0F0 -> ready=1 in the write cycle (bypass), and pending=0 after the edge;
   - reserve and write r2 in the same cycle -> pending[2]=1.
5. ZERO_REG=1:
   - wr0 r0=9'h1FF -> rd0(r0)=0, ready=1;
   - rsv r0 -> pending stays 0;
   - rd address 5 with DEPTH=4, ADDR_W=3 -> data 0, ready=1.
6. Reset mid-operation: rsv r1 and r3, assert rst together with wr1 r1=9'h077 -> storage r1=0, pending=0, and the write is discarded.
